// File: rtl/cursor_sprite_ctrl.sv
// Cursor sprite sequencer: fetches outline/fill glyph rows in hblank and
// emits a registered 2-bit pixel class during active video, with blink.
module cursor_sprite_ctrl #(
    parameter int BLINK_FRAMES = 30,
    parameter int BLINK_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        line_req,
    input  logic [10:0] line_y,
    input  logic [10:0] pix_x,
    input  logic        video_on,
    input  logic [10:0] cur_x,
    input  logic [10:0] cur_y,
    input  logic [1:0]  cur_kind,
    input  logic        blink_en,
    output logic [10:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [1:0]  cursor_px,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_O,
        CAP_O,
        CAP_F
    } state_e;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    state_e              state_q;
    logic [10:0]         rom_addr_q;
    logic                busy_q;
    logic [15:0]         obuf_q;
    logic [15:0]         fbuf_q;
    logic                hit_q;
    logic [3:0]          frow_q;
    logic [1:0]          fkind_q;
    logic [10:0]         cx_q;
    logic [10:0]         cy_q;
    logic [1:0]          kind_q;
    logic                ben_q;
    logic [BLINK_W-1:0]  cnt_q;
    logic                phase_q;
    logic [1:0]          px_q;

    logic [10:0] row_d;
    logic        row_hit_d;
    logic [10:0] col_d;
    logic [3:0]  idx_d;
    logic        on_d;
    logic [1:0]  px_d;

    // Lines above the sprite wrap to large rows and therefore miss.
    assign row_d     = line_y - cy_q;
    assign row_hit_d = row_d < 11'd16;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q    <= '0;
            cy_q    <= '0;
            kind_q  <= '0;
            ben_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (frame_tick) begin
            cx_q   <= cur_x;
            cy_q   <= cur_y;
            kind_q <= (cur_kind == 2'd3) ? 2'd0 : cur_kind;
            ben_q  <= blink_en;
            if (!blink_en) begin
                cnt_q   <= '0;
                phase_q <= 1'b1;
            end else if (cnt_q == BLINK_LAST) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A new line_req always wins, aborting any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            obuf_q     <= '0;
            fbuf_q     <= '0;
            hit_q      <= 1'b0;
            frow_q     <= '0;
            fkind_q    <= '0;
        end else if (line_req) begin
            hit_q <= 1'b0;
            if (row_hit_d) begin
                rom_addr_q <= {4'b0, kind_q, 1'b0, row_d[3:0]};
                frow_q     <= row_d[3:0];
                fkind_q    <= kind_q;
                busy_q     <= 1'b1;
                state_q    <= FETCH_O;
            end else begin
                obuf_q  <= '0;
                fbuf_q  <= '0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                FETCH_O: begin
                    rom_addr_q <= {4'b0, fkind_q, 1'b1, frow_q};
                    state_q    <= CAP_O;
                end
                CAP_O: begin
                    obuf_q  <= rom_data;
                    state_q <= CAP_F;
                end
                CAP_F: begin
                    fbuf_q  <= rom_data;
                    hit_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign col_d = pix_x - cx_q;
    assign idx_d = 4'hF - col_d[3:0];
    assign on_d  = video_on & hit_q & (col_d < 11'd16)
                 & (phase_q | ~ben_q);

    always_comb begin
        px_d = 2'b00;
        if (on_d) begin
            if (obuf_q[idx_d])      px_d = 2'b10;
            else if (fbuf_q[idx_d]) px_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) px_q <= 2'b00;
        else        px_q <= px_d;
    end

    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;
    assign cursor_px = px_q;

endmodule

// File: tb/tb_cursor_sprite_ctrl.sv
// Bench for cursor_sprite_ctrl: glyph ROM model, frame/line model and
// per-pixel reference computed from the sprite rules.
module tb_cursor_sprite_ctrl;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        line_req = 1'b0;
    logic [10:0] line_y = '0;
    logic [10:0] pix_x = '0;
    logic        video_on = 1'b0;
    logic [10:0] cur_x = '0;
    logic [10:0] cur_y = '0;
    logic [1:0]  cur_kind = '0;
    logic        blink_en = 1'b0;
    logic [10:0] rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  cursor_px;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [10:0] m_x, m_y, m_addr;
    int          m_kind, m_k;
    bit          m_ben, m_hit;
    logic [15:0] m_o, m_f;

    cursor_sprite_ctrl #(.BLINK_FRAMES(BF), .BLINK_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .line_req(line_req), .line_y(line_y), .pix_x(pix_x),
        .video_on(video_on), .cur_x(cur_x), .cur_y(cur_y),
        .cur_kind(cur_kind), .blink_en(blink_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cursor_px(cursor_px), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] glyph(input logic [10:0] a);
        case (a)
            11'h005: glyph = 16'hCC33;
            11'h015: glyph = 16'hF3CF;
            11'h023: glyph = 16'h9000;
            11'h033: glyph = 16'hF000;
            default: glyph = (16'(a) * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clk) rom_data <= glyph(rom_addr);

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_px(input logic [10:0] px,
                                        input bit von);
        logic [10:0] col;
        bit vis;
        int c;
        col = px - m_x;
        vis = !m_ben || ((m_k / BF) % 2 == 0);
        if (!von || !m_hit || col >= 11'd16 || !vis) return 2'b00;
        c = int'(col);
        if (m_o[15-c]) return 2'b10;
        if (m_f[15-c]) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_tick(input logic [10:0] x, input logic [10:0] y,
                              input logic [1:0] kd, input bit be);
        m_x    = x;
        m_y    = y;
        m_kind = (kd == 2'd3) ? 0 : int'(kd);
        m_ben  = be;
        m_k    = be ? m_k + 1 : 0;
    endtask

    task automatic model_reset();
        m_x = '0; m_y = '0; m_addr = '0;
        m_kind = 0; m_k = 0; m_ben = 0; m_hit = 0;
        m_o = '0; m_f = '0;
    endtask

    task automatic scramble();
        cur_x    = 11'($urandom);
        cur_y    = 11'($urandom);
        cur_kind = 2'($urandom);
        blink_en = 1'($urandom);
    endtask

    task automatic frame(input logic [10:0] x, input logic [10:0] y,
                         input logic [1:0] kd, input bit be);
        @(negedge clk);
        cur_x = x; cur_y = y; cur_kind = kd; blink_en = be;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_tick(x, y, kd, be);
        scramble();
    endtask

    task automatic start_only(input logic [10:0] ly);
        @(negedge clk);
        line_req = 1'b1; line_y = ly; video_on = 1'b0;
        @(posedge clk); #1;
        line_req = 1'b0;
        m_addr = 11'(m_kind * 2 * 16 + int'(ly - m_y));
        m_hit = 0;
        chk("abort_addr_o", 16'(rom_addr), 16'(m_addr));
        chk("abort_busy", 16'(busy), 16'd1);
    endtask

    task automatic do_line(input logic [10:0] ly, input bit mid_tick);
        logic [10:0] row, a_o, a_f;
        row = ly - m_y;
        @(negedge clk);
        line_req = 1'b1; line_y = ly; video_on = 1'b0;
        @(posedge clk); #1;
        line_req = 1'b0;
        line_y = 11'($urandom);
        m_hit = 0;
        if (row < 11'd16) begin
            a_o = 11'(m_kind * 2 * 16 + int'(row));
            a_f = 11'((m_kind * 2 + 1) * 16 + int'(row));
            chk("addr_o", 16'(rom_addr), 16'(a_o));
            chk("busy_c1", 16'(busy), 16'd1);
            if (mid_tick) begin
                @(negedge clk);
                frame_tick = 1'b1;
                @(posedge clk); #1;
                frame_tick = 1'b0;
                model_tick(cur_x, cur_y, cur_kind, blink_en);
                scramble();
            end else begin
                @(posedge clk); #1;
            end
            chk("addr_f", 16'(rom_addr), 16'(a_f));
            chk("busy_c2", 16'(busy), 16'd1);
            @(posedge clk); #1;
            chk("busy_c3", 16'(busy), 16'd1);
            @(posedge clk); #1;
            chk("busy_done", 16'(busy), 16'd0);
            m_o = glyph(a_o); m_f = glyph(a_f);
            m_hit = 1; m_addr = a_f;
        end else begin
            m_o = '0; m_f = '0;
            for (int i = 0; i < 3; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                chk("miss_busy", 16'(busy), 16'd0);
                chk("miss_addr", 16'(rom_addr), 16'(m_addr));
            end
        end
    endtask

    task automatic sweep();
        for (int i = -2; i < 18; i++) begin
            @(negedge clk);
            pix_x = m_x + 11'(i);
            video_on = ($urandom_range(7) != 0);
            @(posedge clk); #1;
            chk("px", 16'(cursor_px), 16'(m_px(pix_x, video_on)));
        end
        video_on = 1'b0;
    endtask

    initial begin
        logic [10:0] ry;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_px", 16'(cursor_px), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_addr", 16'(rom_addr), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        frame(11'd200, 11'd100, 2'd0, 1'b0);
        do_line(11'd105, 1'b0);
        sweep();
        do_line(11'd99, 1'b0);
        sweep();
        do_line(11'd116, 1'b0);
        sweep();

        ry = 11'($urandom_range(1000));
        frame(11'($urandom_range(1800)), ry, 2'd1, 1'b0);
        do_line(ry + 11'd3, 1'b0);
        sweep();
        frame(11'($urandom_range(1800)), ry, 2'd3, 1'b0);
        do_line(ry + 11'd5, 1'b0);
        sweep();

        do_line(m_y + 11'd7, 1'b1);
        sweep();

        start_only(m_y + 11'd2);
        do_line(m_y + 11'd9, 1'b0);
        sweep();
        start_only(m_y + 11'd1);
        do_line(m_y - 11'd1, 1'b0);
        sweep();

        for (int f = 0; f < 8; f++) begin
            frame(11'd300, 11'd50, 2'd0, 1'b1);
            do_line(11'd55, 1'b0);
            sweep();
        end

        for (int n = 0; n < 30; n++) begin
            ry = 11'($urandom);
            frame(11'($urandom), ry, 2'($urandom), 1'($urandom));
            do_line(ry + 11'($urandom_range(24)) - 11'd4, 1'($urandom));
            sweep();
        end

        frame(11'd40, 11'd20, 2'd2, 1'b0);
        do_line(11'd22, 1'b0);
        @(negedge clk);
        pix_x = m_x; video_on = 1'b1;
        line_req = 1'b1; line_y = 11'd25;
        @(posedge clk); #1;
        line_req = 1'b0;
        chk("px_pre_rst", 16'(cursor_px), 16'(m_px(pix_x, 1'b1)));
        rst_n = 1'b0;
        #1;
        chk("midrst_px", 16'(cursor_px), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_addr", 16'(rom_addr), 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sweep();
        do_line(11'd3, 1'b0);
        sweep();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
